// File: rtl/rr_arb_requester.sv
// Requester-side agent for a two-port round-robin arbiter.
// Words from a local producer are buffered in a small FIFO. While words are
// waiting, the block requests the shared bus and forwards one word per
// granted, accepted cycle. After MAX_BURST beats it drops req for one cycle
// so the other port gets a turn.
//
// Handshakes: a push happens when in_valid && in_ready, and a beat (pop)
// happens when bus_valid && bus_ready. Once bus_valid is raised, bus_data
// stays stable until the word is accepted. bus_valid is qualified each cycle
// by arb_grant, and arb_req never depends on arb_grant.
module rr_arb_requester #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       arb_req,
  input  logic                       arb_grant,
  output logic                       bus_valid,
  output logic [DATA_W-1:0]          bus_data,
  input  logic                       bus_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [15:0]                beats_sent,
  output logic [1:0]                 dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(MAX_BURST) + 1;

  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_BACKOFF = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_d;
  logic              in_ready_q;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [BW-1:0]     beat_cnt_q;
  logic [BW-1:0]     beat_cnt_d;
  logic              req_q;
  logic [15:0]       beats_q;

  logic push;
  logic pop;

  // in_ready is a registered copy of !full, so a pop in the same cycle
  // cannot reopen the FIFO to a word while it is full.
  assign push = in_valid && in_ready_q;
  assign pop  = bus_valid && bus_ready;

  assign bus_valid  = (state_q == S_REQ) && arb_grant && (count_q != '0);
  assign bus_data   = mem_q[rd_ptr_q];
  assign in_ready   = in_ready_q;
  assign arb_req    = req_q;
  assign fifo_count = count_q;
  assign beats_sent = beats_q;
  assign dbg_state  = state_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Request tenure FSM. The burst limit wins over the empty check.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (count_d != '0) state_d = S_REQ;
      end
      S_REQ: begin
        if (pop) begin
          if (beat_cnt_q == LAST_BEAT) begin
            state_d    = S_BACKOFF;
            beat_cnt_d = '0;
          end else if ((count_q == CW'(1)) && !push) begin
            state_d    = S_IDLE;
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      S_BACKOFF: begin
        state_d = (count_d != '0) ? S_REQ : S_IDLE;
      end
      default: begin
        state_d    = S_IDLE;
        beat_cnt_d = '0;
      end
    endcase
  end

  // FIFO storage is not reset, so buffered data is simply discarded.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Pointers, occupancy, ready flag and the beat counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b1;
      beats_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      in_ready_q <= (count_d != FULL_CNT);
      if (pop) beats_q <= beats_q + 16'd1;
    end
  end

  // FSM state, burst counter and the registered request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      req_q      <= (state_d == S_REQ);
    end
  end

endmodule

// File: tb/tb_rr_arb_requester.sv
// Directed bench for rr_arb_requester. Accepted pushes go into an expected
// queue, and each bus beat pops the queue and compares the data.
module tb_rr_arb_requester;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              arb_req;
  logic              arb_grant;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_ready;
  logic [2:0]        fifo_count;
  logic [15:0]       beats_sent;
  logic [1:0]        dbg_state;

  logic [DATA_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  rr_arb_requester #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .arb_req    (arb_req),
    .arb_grant  (arb_grant),
    .bus_valid  (bus_valid),
    .bus_data   (bus_data),
    .bus_ready  (bus_ready),
    .fifo_count (fifo_count),
    .beats_sent (beats_sent),
    .dbg_state  (dbg_state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sample the handshakes mid-cycle, when the signals are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (bus_valid && bus_ready) begin
        if (exp_q.size() == 0) begin
          chk("pop_on_empty_queue", 32'd1, 32'd0);
        end else begin
          chk("bus_data", {24'd0, bus_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  logic [8:0] req_t;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; arb_grant = 1'b0; bus_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, arb_req}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    chk("rst_beats", {16'd0, beats_sent}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Single word.
    in_valid = 1'b1; in_data = 8'hA5; arb_grant = 1'b1; bus_ready = 1'b1;
    @(negedge clk);
    chk("t1_req_c0", {31'd0, arb_req}, 32'd0);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_req_c1", {31'd0, arb_req}, 32'd1);
    chk("t1_valid_c1", {31'd0, bus_valid}, 32'd1);
    chk("t1_data_c1", {24'd0, bus_data}, 32'hA5);
    next_cycle();
    @(negedge clk);
    chk("t1_req_c2", {31'd0, arb_req}, 32'd0);
    chk("t1_valid_c2", {31'd0, bus_valid}, 32'd0);
    chk("t1_beats", {16'd0, beats_sent}, 32'd1);
    next_cycle();

    // Burst split at four beats.
    req_t = 9'b011011110;
    for (int i = 0; i < 9; i++) begin
      in_valid = (i < 6);
      in_data  = 8'(i + 1);
      @(negedge clk);
      chk($sformatf("t2_req_%0d", i), {31'd0, arb_req}, {31'd0, req_t[i]});
      chk($sformatf("t2_valid_%0d", i), {31'd0, bus_valid}, {31'd0, req_t[i]});
      next_cycle();
    end
    @(negedge clk);
    chk("t2_beats", {16'd0, beats_sent}, 32'd7);
    chk("t2_count", {29'd0, fifo_count}, 32'd0);
    chk("t2_idle", {30'd0, dbg_state}, 32'd0);
    next_cycle();

    // Rotating grant with a full FIFO: gaps keep the burst count, and the
    // fourth beat goes to backoff although it also empties the FIFO.
    arb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h11 + i);
      next_cycle();
    end
    in_valid = 1'b0;
    req_t = 9'b001111111;
    for (int k = 0; k < 9; k++) begin
      arb_grant = (k % 2 == 0);
      @(negedge clk);
      if (k == 0) begin
        chk("t3_count_full", {29'd0, fifo_count}, 32'd4);
        chk("t3_in_ready_full", {31'd0, in_ready}, 32'd0);
      end
      chk($sformatf("t3_req_%0d", k), {31'd0, arb_req}, {31'd0, req_t[k]});
      chk($sformatf("t3_valid_%0d", k), {31'd0, bus_valid}, {31'd0, req_t[k] && (k % 2 == 0)});
      if (k == 7) chk("t3_backoff", {30'd0, dbg_state}, 32'd2);
      next_cycle();
    end
    arb_grant = 1'b0;
    @(negedge clk);
    chk("t3_beats", {16'd0, beats_sent}, 32'd11);
    next_cycle();

    // Bus stall.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h21 + i);
      next_cycle();
    end
    in_valid = 1'b0; arb_grant = 1'b1; bus_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t4_valid_%0d", i), {31'd0, bus_valid}, 32'd1);
      chk($sformatf("t4_data_%0d", i), {24'd0, bus_data}, 32'h21);
      chk($sformatf("t4_count_%0d", i), {29'd0, fifo_count}, 32'd2);
      chk($sformatf("t4_beats_%0d", i), {16'd0, beats_sent}, 32'd11);
      next_cycle();
    end
    bus_ready = 1'b1;
    next_cycle();
    bus_ready = 1'b0;
    @(negedge clk);
    chk("t4_count_after_one", {29'd0, fifo_count}, 32'd1);
    chk("t4_data_next", {24'd0, bus_data}, 32'h22);
    chk("t4_beats_after_one", {16'd0, beats_sent}, 32'd12);
    next_cycle();
    bus_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    chk("t4_count_empty", {29'd0, fifo_count}, 32'd0);
    chk("t4_beats", {16'd0, beats_sent}, 32'd13);
    chk("t4_req_idle", {31'd0, arb_req}, 32'd0);
    next_cycle();

    // Full FIFO: extra words dropped, then drained in order.
    arb_grant = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h30 + i);
      @(negedge clk);
      chk($sformatf("t5_in_ready_%0d", i), {31'd0, in_ready}, {31'd0, i < DEPTH});
      next_cycle();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_count_full", {29'd0, fifo_count}, 32'd4);
    chk("t5_queue_depth", exp_q.size(), 32'd4);
    next_cycle();
    arb_grant = 1'b1;
    repeat (8) next_cycle();
    @(negedge clk);
    chk("t5_drained", exp_q.size(), 32'd0);
    chk("t5_count_empty", {29'd0, fifo_count}, 32'd0);
    chk("t5_beats", {16'd0, beats_sent}, 32'd17);
    next_cycle();

    // Reset in the middle of a burst.
    arb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h41 + i);
      next_cycle();
    end
    in_valid = 1'b0; arb_grant = 1'b1;
    repeat (2) next_cycle();
    chk("t6_beats_before_rst", {16'd0, beats_sent}, 32'd19);
    rst = 1'b1;
    #1;
    chk("t6_rst_req", {31'd0, arb_req}, 32'd0);
    chk("t6_rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("t6_rst_count", {29'd0, fifo_count}, 32'd0);
    chk("t6_rst_beats", {16'd0, beats_sent}, 32'd0);
    exp_q.delete();
    repeat (2) next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t6_quiet_valid_%0d", i), {31'd0, bus_valid}, 32'd0);
      chk($sformatf("t6_quiet_beats_%0d", i), {16'd0, beats_sent}, 32'd0);
      next_cycle();
    end
    in_valid = 1'b1; in_data = 8'h55;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_new_valid", {31'd0, bus_valid}, 32'd1);
    chk("t6_new_data", {24'd0, bus_data}, 32'h55);
    next_cycle();
    @(negedge clk);
    chk("t6_new_beats", {16'd0, beats_sent}, 32'd1);
    chk("t6_new_count", {29'd0, fifo_count}, 32'd0);
    chk("t6_queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
